lab3_stim_check: RTL

Self-checking stimulus driver for the three-input lab logic block with outputs x = ~c ^ (a | b) and y = (a | b) & (~(a & b) ^ (a | b)), which reduces to y = a & b. On a start request it walks all eight {a,b,c} vectors in order, holds each vector long enough for the device under test to settle, and samples x/y against an internal golden model. It reports a saturating mismatch count, the first failing vector and a pass flag. It is the driving/checking end of that block's interface and is used on-board and in benches.

---
 rtl/lab3_stim_check.sv | 120 ++++++++++++
 1 files changed

// File: rtl/lab3_stim_check.sv
`default_nettype none
// ============================================================================
// Module   : lab3_stim_check
// Brief    : Walks all eight {a,b,c} vectors into the lab logic block and
//            checks x/y against a golden model; reports count/first/pass.
// Revision : 1.0 - initial release
// ============================================================================
module lab3_stim_check #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    input  logic             x_i,
    input  logic             y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_valid,
    output logic [2:0]       first_err_vec
);

    localparam int                 c_CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0]   c_ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [2:0]         r_vec;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_x_exp;
    logic               w_y_exp;
    logic               w_mis;
    logic [ERR_W-1:0]   w_err_next;

    // Golden model; y of the lab block reduces to a & b.
    assign w_x_exp    = ~r_vec[0] ^ (r_vec[2] | r_vec[1]);
    assign w_y_exp    = r_vec[2] & r_vec[1];
    assign w_mis      = (x_i != w_x_exp) || (y_i != w_y_exp);
    assign w_err_next = (w_mis && (err_cnt != c_ERR_MAX)) ? err_cnt + 1'b1 : err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_vec         <= 3'd0;
            r_cnt         <= '0;
            {a_o, b_o, c_o} <= 3'b000;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            err_valid     <= 1'b0;
            first_err_vec <= 3'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec           <= 3'd0;
                        r_cnt           <= '0;
                        err_cnt         <= '0;
                        err_valid       <= 1'b0;
                        first_err_vec   <= 3'd0;
                        pass            <= 1'b0;
                        {a_o, b_o, c_o} <= 3'b000;
                        busy            <= 1'b1;
                        r_state         <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    err_cnt <= w_err_next;
                    if (w_mis && !err_valid) begin
                        first_err_vec <= r_vec;
                        err_valid     <= 1'b1;
                    end
                    // Pass uses the count including this final compare so it lines up with done.
                    if (r_vec == 3'd7) begin
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        pass            <= (w_err_next == '0);
                        {a_o, b_o, c_o} <= 3'b000;
                        r_state         <= S_DONE;
                    end else begin
                        r_vec           <= r_vec + 3'd1;
                        r_cnt           <= '0;
                        {a_o, b_o, c_o} <= r_vec + 3'd1;
                        r_state         <= S_HOLD;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
